// File: rtl/pp_out_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_out_drain_ctrl_pkg
//  Description : Shared types and constants for the output ping-pong drain
//                controller (read FSM encoding, default word width, bank size).
//  Revision    : 1.0 - initial release
// ============================================================================
package pp_out_drain_ctrl_pkg;

    // A result word is one accumulated block chunk.
    localparam int c_top_chunk_size  = 16;
    localparam int c_top_block_size  = 4;
    localparam int c_data_width      = c_top_chunk_size * c_top_block_size;

    // Read-side FSM encoding.
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DRAIN = 2'd1,
        R_WAIT  = 2'd2
    } rd_state_t;

    // Words held by one bank: one burst per matrix column.
    function automatic int blocks_per_bank(input int col_y, input int total_modules);
        return col_y * total_modules;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pp_out_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pp_out_drain_ctrl_if
//  Description : Bundles the result input stream, both output-bank BRAM ports,
//                the drain output stream and the bank status flags.
//                master = controller side, slave = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pp_out_drain_ctrl_if #(
    parameter int DATA_WIDTH = pp_out_drain_ctrl_pkg::c_data_width,
    parameter int ADDR_WIDTH = 4
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  bank0_ena;
    logic                  bank0_wea;
    logic [ADDR_WIDTH-1:0] bank0_addra;
    logic [DATA_WIDTH-1:0] bank0_dina;
    logic                  bank0_enb;
    logic [ADDR_WIDTH-1:0] bank0_addrb;
    logic [DATA_WIDTH-1:0] bank0_doutb;

    logic                  bank1_ena;
    logic                  bank1_wea;
    logic [ADDR_WIDTH-1:0] bank1_addra;
    logic [DATA_WIDTH-1:0] bank1_dina;
    logic                  bank1_enb;
    logic [ADDR_WIDTH-1:0] bank1_addrb;
    logic [DATA_WIDTH-1:0] bank1_doutb;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    logic [1:0]            bank_full;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output bank0_ena, bank0_wea, bank0_addra, bank0_dina, bank0_enb, bank0_addrb,
        input  bank0_doutb,
        output bank1_ena, bank1_wea, bank1_addra, bank1_dina, bank1_enb, bank1_addrb,
        input  bank1_doutb,
        output out_valid, out_data, out_last,
        input  out_ready,
        output bank_full
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  bank0_ena, bank0_wea, bank0_addra, bank0_dina, bank0_enb, bank0_addrb,
        output bank0_doutb,
        input  bank1_ena, bank1_wea, bank1_addra, bank1_dina, bank1_enb, bank1_addrb,
        output bank1_doutb,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  bank_full
    );

endinterface
`default_nettype wire

// File: rtl/pp_out_drain_ctrl_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pp_out_drain_ctrl_skid
//  Description : Two-entry FIFO catching BRAM read returns ({last, data}) so
//                that backpressure never drops or repeats a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_out_drain_ctrl_skid #(
    parameter int WIDTH = 65
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic      [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    // Storage is written only, never reset: contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pp_out_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pp_out_drain_ctrl
//  Description : Output ping-pong controller. Result words from the matmul
//                are written into one BRAM bank while the other full bank is
//                drained as a valid/ready stream; the matmul is backpressured
//                when the bank it would write next is still undrained.
//                Optional macro PP_OUT_STALL_CNT_EN adds a saturating 16-bit
//                counter of refused input cycles (port stall_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_out_drain_ctrl
    import pp_out_drain_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = c_data_width,
    parameter int ADDR_WIDTH    = 4,
    parameter int TOTAL_MODULES = 4,
    parameter int COL_Y         = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pp_out_drain_ctrl_if.master  bus
`ifdef PP_OUT_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int                    BLOCKS_PER_BANK = blocks_per_bank(COL_Y, TOTAL_MODULES);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr     = ADDR_WIDTH'(BLOCKS_PER_BANK - 1);

    // ---------------- write side ----------------
    logic                  r_wr_sel;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [1:0]            r_bank_full;
    logic                  w_in_ready;
    logic                  w_wr_fire;
    logic                  w_wr_last;

    // ---------------- read side ----------------
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_next;
    logic                  r_rd_sel;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_inflight_bank;
    logic                  w_issue;
    logic                  w_rd_release;
    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic [DATA_WIDTH:0]   w_skid_head;
    logic [1:0]            w_skid_count;
    logic                  w_skid_empty;
    logic                  w_out_valid;
    logic                  w_out_last;
    logic                  w_out_fire;
    logic [1:0]            w_full_set;
    logic [1:0]            w_full_clr;

    assign w_in_ready = ~r_bank_full[r_wr_sel];
    assign w_wr_fire  = bus.in_valid & w_in_ready;
    assign w_wr_last  = w_wr_fire && (r_wr_addr == c_last_addr);

    // Write pointer: walk the bank, then hand it to the drain side and flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel  <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wr_addr <= '0;
                r_wr_sel  <= ~r_wr_sel;
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Set and clear always target different banks, so both apply together.
    assign w_full_set = {w_wr_last & r_wr_sel, w_wr_last & ~r_wr_sel};
    assign w_full_clr = {w_rd_release & r_rd_sel, w_rd_release & ~r_rd_sel};

    // Bank ownership flags.
    always_ff @(posedge clk) begin
        if (rst) r_bank_full <= 2'b00;
        else     r_bank_full <= (r_bank_full | w_full_set) & ~w_full_clr;
    end

    // Reads in flight plus buffered words never exceed the skid depth.
    assign w_occ        = w_skid_count + {1'b0, r_inflight};
    assign w_skid_empty = (w_skid_count == 2'd0);
    assign w_ret_data   = r_inflight_bank ? bus.bank1_doutb : bus.bank0_doutb;
    assign w_out_valid  = ~w_skid_empty | r_inflight;
    assign w_out_last   = w_skid_empty ? r_inflight_last : w_skid_head[DATA_WIDTH];
    assign w_out_fire   = w_out_valid & bus.out_ready;

    // Drain FSM next state. Leaving IDLE also looks at a bank completing this
    // cycle so the first read issues in the cycle bank_full becomes visible.
    always_comb begin
        w_rd_state_next = r_rd_state;
        w_issue         = 1'b0;
        w_rd_release    = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (r_bank_full[r_rd_sel] || (w_wr_last && (r_wr_sel == r_rd_sel)))
                    w_rd_state_next = R_DRAIN;
            end
            R_DRAIN: begin
                if (w_occ < 2'd2) begin
                    w_issue = 1'b1;
                    if (r_rd_addr == c_last_addr) w_rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (w_out_fire && w_out_last) begin
                    w_rd_release    = 1'b1;
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    // Drain FSM state, read pointer and in-flight read tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state      <= R_IDLE;
            r_rd_sel        <= 1'b0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_inflight_bank <= 1'b0;
        end else begin
            r_rd_state      <= w_rd_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == c_last_addr);
            r_inflight_bank <= r_rd_sel;
            if (w_issue) r_rd_addr <= (r_rd_addr == c_last_addr) ? '0 : r_rd_addr + 1'b1;
            if (w_rd_release) r_rd_sel <= ~r_rd_sel;
        end
    end

    // Returning data bypasses the skid when it is empty and downstream is ready.
    pp_out_drain_ctrl_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight & ~(w_skid_empty & bus.out_ready)),
        .i_data  ({r_inflight_last, w_ret_data}),
        .i_pop   (bus.out_ready & ~w_skid_empty),
        .o_data  (w_skid_head),
        .o_count (w_skid_count)
    );

    assign bus.in_ready    = w_in_ready;
    assign bus.bank_full   = r_bank_full;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_last    = w_out_valid & w_out_last;
    assign bus.out_data    = w_skid_empty ? w_ret_data : w_skid_head[DATA_WIDTH-1:0];

    assign bus.bank0_ena   = w_wr_fire & ~r_wr_sel;
    assign bus.bank0_wea   = w_wr_fire & ~r_wr_sel;
    assign bus.bank0_addra = (w_wr_fire & ~r_wr_sel) ? r_wr_addr : '0;
    assign bus.bank0_dina  = bus.in_data;
    assign bus.bank0_enb   = w_issue & ~r_rd_sel;
    assign bus.bank0_addrb = (w_issue & ~r_rd_sel) ? r_rd_addr : '0;

    assign bus.bank1_ena   = w_wr_fire & r_wr_sel;
    assign bus.bank1_wea   = w_wr_fire & r_wr_sel;
    assign bus.bank1_addra = (w_wr_fire & r_wr_sel) ? r_wr_addr : '0;
    assign bus.bank1_dina  = bus.in_data;
    assign bus.bank1_enb   = w_issue & r_rd_sel;
    assign bus.bank1_addrb = (w_issue & r_rd_sel) ? r_rd_addr : '0;

`ifdef PP_OUT_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles the matmul is held off, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= 16'h0000;
        else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'h0001;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pp_out_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_out_drain_ctrl
//  Description : Directed self-checking bench for pp_out_drain_ctrl with a
//                behavioural two-bank BRAM model (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_out_drain_ctrl;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   skid_max;

    pp_out_drain_ctrl_if bus ();

`ifdef PP_OUT_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pp_out_drain_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PP_OUT_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM banks.
    logic [63:0] mem0 [16];
    logic [63:0] mem1 [16];
    always @(posedge clk) begin
        if (bus.bank0_ena && bus.bank0_wea) mem0[bus.bank0_addra] <= bus.bank0_dina;
        if (bus.bank1_ena && bus.bank1_wea) mem1[bus.bank1_addra] <= bus.bank1_dina;
        if (bus.bank0_enb) bus.bank0_doutb <= mem0[bus.bank0_addrb];
        if (bus.bank1_enb) bus.bank1_doutb <= mem1[bus.bank1_addrb];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Concurrent fill and drain. opat: 0 = out_ready high, 2 = toggling 1,0,1,0.
    task automatic run(input int n_in, input logic [63:0] base, input int opat,
                       input int n_out, input bit chk_rdy, input int budget);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit rel  = 1'b0;
        skid_max = 0;
        while ((sent < n_in || got < n_out) && cyc < budget) begin
            bus.in_valid  = (sent < n_in);
            bus.in_data   = base + 64'(sent);
            bus.out_ready = (opat == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            if (int'(dut.w_skid_count) > skid_max) skid_max = int'(dut.w_skid_count);
            if (rel) begin
                check("in_ready_after_release", 64'(bus.in_ready), 64'd1);
                rel = 1'b0;
            end
            if (chk_rdy && bus.in_valid) check("in_ready_during_fill", 64'(bus.in_ready), 64'd1);
            if (bus.in_valid && bus.in_ready) begin
                if (chk_rdy)
                    check("write_bank_sel", {62'd0, bus.bank1_ena, bus.bank0_ena},
                          ((sent / 8) % 2 == 0) ? 64'd1 : 64'd2);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_data_order", bus.out_data, base + 64'(got));
                check("out_last_pos", 64'(bus.out_last), 64'(((got + 1) % 8) == 0));
                if (bus.out_last) rel = 1'b1;
                got++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("words_out_count", 64'(got), 64'(n_out));
    endtask

    // Offer 24 words with out_ready low: only two banks' worth fit.
    task automatic fill_blocked();
        int acc = 0;
        for (int c = 0; c < 24; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'(acc + 1);
            bus.out_ready = 1'b0;
            @(negedge clk);
            check("blocked_in_ready", 64'(bus.in_ready), 64'(c < 16));
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("blocked_accepted", 64'(acc), 64'd16);
        check("blocked_bank_full", 64'(bus.bank_full), 64'd3);
        check("blocked_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // ---- reset state and exact single-bank timing ----
        do_reset();
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_bank_full", 64'(bus.bank_full), 64'd0);
        check("rst_enables",   {60'd0, bus.bank0_ena, bus.bank0_enb, bus.bank1_ena, bus.bank1_enb}, 64'd0);
        tick();
        for (int c = 0; c < 18; c++) begin
            bus.in_valid  = (c < 8);
            bus.in_data   = 64'(c + 1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (c < 8) begin
                check("t1_in_ready", 64'(bus.in_ready), 64'd1);
                check("t1_addra", 64'(bus.bank0_addra), 64'(c));
            end
            if (c == 8) begin
                check("t1_full_set", 64'(bus.bank_full), 64'd1);
                check("t1_first_issue", {62'd0, bus.bank0_enb, 1'b0}, 64'd2);
                check("t1_no_valid_yet", 64'(bus.out_valid), 64'd0);
            end
            if (c >= 9 && c <= 16) begin
                check("t1_out_valid", 64'(bus.out_valid), 64'd1);
                check("t1_out_data", bus.out_data, 64'(c - 8));
                check("t1_out_last", 64'(bus.out_last), 64'(c == 16));
            end
            if (c == 17) begin
                check("t1_full_clear", 64'(bus.bank_full), 64'd0);
                check("t1_idle_valid", 64'(bus.out_valid), 64'd0);
            end
            tick();
        end
        bus.in_valid = 1'b0;

        // ---- two banks back to back ----
        do_reset();
        run(16, 64'd1, 0, 16, 1'b1, 80);

        // ---- both banks full, then drain ----
        do_reset();
        fill_blocked();
`ifdef PP_OUT_STALL_CNT_EN
        check("stall_cnt_8", 64'(stall_cnt), 64'd8);
`endif
        run(0, 64'd1, 0, 16, 1'b0, 80);

        // ---- toggling out_ready ----
        do_reset();
        run(8, 64'd1, 2, 8, 1'b0, 80);
        check("skid_max_le2", 64'(skid_max <= 2), 64'd1);

        // ---- reset in the middle of a drain ----
        do_reset();
        run(8, 64'd1, 0, 4, 1'b0, 60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_bank_full", 64'(bus.bank_full), 64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        tick();
        run(8, 64'h11, 0, 8, 1'b0, 60);

`ifdef PP_OUT_STALL_CNT_EN
        // ---- stall counter saturation ----
        do_reset();
        @(negedge clk);
        check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
        tick();
        fill_blocked();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 70000; c++) tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pp_out_drain_ctrl.md
Name: pp_out_drain_ctrl

Overview:
Output-side counterpart of the input ping-pong controller. It accepts accumulated result words from the matmul/systolic wrapper into two output BRAM banks in ping-pong fashion. It then drains each full bank as a valid/ready stream to the next Multi-Head Attention stage. Write and drain run concurrently on opposite banks, and the block backpressures the matmul when both banks are full.

Parameters:
DATA_WIDTH, 64, result word width (one accumulated block chunk)
ADDR_WIDTH, 4, bank address width
TOTAL_MODULES, 4, result words produced per acc_done burst
COL_Y, 2, bursts per bank (columns of resulting matrix row)
BLOCKS_PER_BANK, COL_Y*TOTAL_MODULES (derived localparam), words per bank; must be <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  result word valid from matmul
in_data  in  DATA_WIDTH  result word
in_ready  out  1  can accept in_data this cycle
bank0_ena  out  1  bank0 write-port enable
bank0_wea  out  1  bank0 write enable
bank0_addra  out  ADDR_WIDTH  bank0 write address
bank0_dina  out  DATA_WIDTH  bank0 write data (=in_data)
bank0_enb  out  1  bank0 read-port enable
bank0_addrb  out  ADDR_WIDTH  bank0 read address
bank0_doutb  in  DATA_WIDTH  bank0 read data, 1-cycle latency
bank1_* (ena, wea, addra, dina, enb, addrb, doutb)  same as bank0
out_valid  out  1  output word valid
out_data  out  DATA_WIDTH  output word
out_last  out  1  final word of a bank
out_ready  in  1  downstream accepts word
bank_full  out  2  bank i holds undrained data

Behaviour:
- Reset (rst=1 at posedge): wr_sel=0, rd_sel=0, wr_addr=0, rd_addr=0, bank_full=00, skid empty, rd FSM=R_IDLE. Outputs: in_ready=1, out_valid=0, out_last=0, all en/we=0, addresses 0. In-flight reads are discarded. Reset mid-operation needs no flush.
- Write side:
  - in_ready = ~bank_full[wr_sel].
  - On in_valid&in_ready, write in_data to bank[wr_sel] at wr_addr (ena=wea=1, combinational) and increment wr_addr.
  - At wr_addr==BLOCKS_PER_BANK-1 with acceptance: wr_addr<=0, bank_full[wr_sel]<=1, wr_sel toggles.
  - in_valid while in_ready=0 is ignored; the matmul holds the word.
- Read FSM, states R_IDLE/R_DRAIN/R_WAIT:
  - R_IDLE -> R_DRAIN when bank_full[rd_sel]=1.
  - R_DRAIN: issue a read (enb=1, addrb=rd_addr on bank[rd_sel]) when skid_count+inflight<2. At the issue with rd_addr==BLOCKS_PER_BANK-1, go to R_WAIT and set rd_addr<=0.
  - R_WAIT: when the last word (out_last) handshakes, clear bank_full[rd_sel], toggle rd_sel, and go to R_IDLE.
  - Tag each issued read with last = (rd_addr==BLOCKS_PER_BANK-1). Returned data enters a 2-entry skid FIFO. out_valid=skid non-empty; out_data/out_last come from the head. Pop on out_valid&out_ready.
- Latency:
  - The last write is accepted in cycle N. bank_full is set at N+1 and the first read issues in N+1. out_valid=1 in N+2.
  - With out_ready held 1: 1 word/cycle, out_last in cycle N+1+BLOCKS_PER_BANK.
- Simultaneous events:
  - Set and clear of bank_full in the same cycle apply to different banks by construction; both take effect.
  - If a write completes into bank k in the same cycle the drain releases bank k, the write stalls. in_ready=0 that cycle, so the sequence is impossible.
  - out_ready deasserted: issue stops once skid+inflight=2. No word is lost or duplicated.
- Bank port enables are 0 except during a write or read issue.

Optional Feature:
PP_OUT_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0]. It increments each cycle in_valid=1&in_ready=0 and saturates at 16'hFFFF. rst clears it.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- top_pkg: rd_state_t enum (R_IDLE, R_DRAIN, R_WAIT) and the BLOCKS_PER_BANK computation helper. DATA_WIDTH defaults derive from TOP_CHUNK_SIZE/TOP_BLOCK_SIZE.
- One sub-module: pp_out_skid, a 2-entry FIFO of {last, data} with push/pop/count, synchronous active-high reset.

Test Plan:
1. Defaults (BLOCKS_PER_BANK=8), out_ready=1, 8 words 0x1..0x8 back-to-back starting cycle 0 -> bank_full=01 at cycle 8; out_data 0x1..0x8 in cycles 9..16; out_last only in cycle 16; bank_full=00 at cycle 17.
2. 16 words continuous, out_ready=1 -> in_ready stays 1, wr_sel toggles after word 8, 16 words out in order with two out_last pulses.
3. out_ready=0, 24 words offered -> 16 accepted, in_ready=0 from cycle 16, bank_full=11. Then out_ready=1 -> drain bank0 then bank1, in_ready returns 1 after bank0 released.
4. out_ready toggling 1,0,1,0 during drain -> exactly 8 unique words, no duplicates or gaps, skid count never exceeds 2.
5. rst asserted mid-drain (after word 4 out) -> next cycle out_valid=0, bank_full=00, in_ready=1; a new 8-word fill drains from address 0.
6. PP_OUT_STALL_CNT_EN defined, scenario 3 with 8 refused cycles -> stall_cnt=8; forced 70000 stall cycles -> 16'hFFFF.
